// File: rtl/instruction_assembler_if.sv
// Byte-link and issue bus of instruction_assembler.
//   master : host side. Drives i_byte, i_byte_valid and i_vblank, and observes the outputs.
//   slave  : the assembler itself.
//   Signals:
//     i_byte / i_byte_valid   received byte and its one-cycle strobe
//     i_vblank                vertical blanking flag
//     o_instruction           issued word ([7:0] opcode, [31:8] args)
//     o_instruction_ready     one-cycle issue strobe
//     o_fifo_full             FIFO holds its full depth of words
//     o_overflow              sticky flag: a completed word was dropped
//     o_timeout               one-cycle pulse: a partial word was discarded
interface instruction_assembler_if;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        i_vblank;
  logic [31:0] o_instruction;
  logic        o_instruction_ready;
  logic        o_fifo_full;
  logic        o_overflow;
  logic        o_timeout;

  modport master (
    output i_byte, i_byte_valid, i_vblank,
    input  o_instruction, o_instruction_ready, o_fifo_full, o_overflow, o_timeout
  );

  modport slave (
    input  i_byte, i_byte_valid, i_vblank,
    output o_instruction, o_instruction_ready, o_fifo_full, o_overflow, o_timeout
  );
endinterface

// File: rtl/instruction_assembler.sv
// instruction_assembler: packs host-link bytes (LSB first, opcode byte first) into 32-bit
// instruction words. It queues them in a circular FIFO and issues each word as a
// one-cycle strobe, at a rate of at most one word every 2 cycles.
// Ports:
//   i_clk      system clock, all logic on posedge
//   i_reset_n  synchronous active-low reset
//   bus        instruction_assembler_if.slave (byte input, vblank, issue outputs, flags)
// Parameters: DEPTH_LOG2 (FIFO depth = 2**DEPTH_LOG2), and BYTE_TIMEOUT (the number of idle
//   cycles after a byte before a partial word is discarded).
// Build option: VBLANK_SYNC_EN. When it is defined, words issue only while i_vblank is high.
//   When it is undefined, words issue as soon as they are queued and i_vblank is unused.
//
// state  | meaning
// S_IDLE | waiting for a queued word and issue permission
// S_ISSUE| strobe cycle; always returns to S_IDLE
module instruction_assembler #(
  parameter int DEPTH_LOG2   = 3,
  parameter int BYTE_TIMEOUT = 50000
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  instruction_assembler_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TW    = $clog2(BYTE_TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(BYTE_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  state_t state, state_next;

  logic [1:0]          byte_cnt;
  logic [23:0]         partial;
  logic [TW-1:0]       idle_cnt;
  logic [31:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr, rptr, wptr_next, rptr_next;
  logic empty, full, full_next, word_done, wr_en, pop, issue_ok, timeout_hit;

`ifdef VBLANK_SYNC_EN
  assign issue_ok = bus.i_vblank;
`else
  logic unused_vblank;
  assign unused_vblank = bus.i_vblank;
  assign issue_ok      = 1'b1;
`endif

  // The MSB of each pointer records the wrap parity. The FIFO is full when the low bits
  // of the two pointers match but their MSBs differ.
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                 (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);

  assign word_done   = bus.i_byte_valid && (byte_cnt == 2'd3);
  assign wr_en       = word_done && !full;
  // An arriving byte takes priority over a timeout on the same edge.
  assign timeout_hit = !bus.i_byte_valid && (byte_cnt != 2'd0) && (idle_cnt == TO_LAST);

  assign wptr_next = wptr + (DEPTH_LOG2 + 1)'(wr_en);
  assign rptr_next = rptr + (DEPTH_LOG2 + 1)'(pop);
  assign full_next = (wptr_next[DEPTH_LOG2] != rptr_next[DEPTH_LOG2]) &&
                     (wptr_next[DEPTH_LOG2-1:0] == rptr_next[DEPTH_LOG2-1:0]);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && issue_ok) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wptr[DEPTH_LOG2-1:0]] <= {bus.i_byte, partial};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state                   <= S_IDLE;
      wptr                    <= '0;
      rptr                    <= '0;
      byte_cnt                <= 2'd0;
      partial                 <= '0;
      idle_cnt                <= '0;
      bus.o_instruction       <= '0;
      bus.o_instruction_ready <= 1'b0;
      bus.o_fifo_full         <= 1'b0;
      bus.o_overflow          <= 1'b0;
      bus.o_timeout           <= 1'b0;
    end else begin
      state           <= state_next;
      wptr            <= wptr_next;
      rptr            <= rptr_next;
      bus.o_fifo_full <= full_next;
      bus.o_timeout   <= timeout_hit;
      if (word_done && full) bus.o_overflow <= 1'b1;

      bus.o_instruction_ready <= pop;
      if (pop) bus.o_instruction <= mem[rptr[DEPTH_LOG2-1:0]];

      if (bus.i_byte_valid) begin
        idle_cnt <= '0;
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    partial[7:0]   <= bus.i_byte;
          2'd1:    partial[15:8]  <= bus.i_byte;
          2'd2:    partial[23:16] <= bus.i_byte;
          default: partial        <= '0;
        endcase
      end else if (byte_cnt != 2'd0) begin
        if (timeout_hit) begin
          byte_cnt <= 2'd0;
          partial  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end
endmodule
